// File: rtl/fors_sig_writer_pkg.sv
// Shared constants and FSM state type for the FORS signature writer.
package fors_sig_writer_pkg;

  localparam int SPX_FORS_TREES  = 22;
  localparam int SPX_FORS_HEIGHT = 14;
  localparam int WORDS           = SPX_FORS_TREES * (1 + SPX_FORS_HEIGHT);

  // Widths of the in-group position counters (tree 0..21, pos 0..14).
  localparam int TREE_W = $clog2(SPX_FORS_TREES);
  localparam int POS_W  = $clog2(SPX_FORS_HEIGHT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/fors_sig_writer_sig_fifo.sv
// Small synchronous FIFO with register-array storage. The head entry is read
// straight from a register, so data is valid the cycle after it is pushed.
// The caller only asserts push/pop when they are legal (push when not full
// or popping the same cycle, pop when not empty).
module fors_sig_writer_sig_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             last
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Storage, pointers and occupancy; storage is cleared so the output reads 0 after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW + 1)'(DEPTH));
  assign last  = (count == (AW + 1)'(1));

endmodule

// File: rtl/fors_sig_writer.sv
// Sink for the FORS signature word stream: buffers words in a small FIFO,
// writes them in order to the signature SRAM, checks the word count and
// latches the FORS root for the hypertree stage.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start
// S_COLLECT | accepting sig words, waiting for fors_done
// S_DRAIN   | root latched, emptying the FIFO into SRAM
// S_DONE    | one-cycle done pulse, then back to idle
module fors_sig_writer
  import fors_sig_writer_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] sig_base,
  input  logic              sig_vld,
  input  logic [255:0]      sig_word,
  input  logic              fors_done,
  input  logic [255:0]      fors_root,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [255:0]      mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [255:0]      fors_pk,
  output logic              overflow
);

  state_t              state;
  logic [TREE_W-1:0]   tree;
  logic [POS_W-1:0]    pos;
  logic                complete;

  logic fifo_empty, fifo_full, fifo_last;
  logic collecting, start_acc, pop;
  logic push_req, push_acc, fifo_drop, extra_word;
  logic last_push, count_ok, drain_fin;

  assign collecting = (state == S_COLLECT) || (state == S_DRAIN);
  assign start_acc  = start && (state == S_IDLE);
  assign mem_we     = !fifo_empty;
  assign pop        = mem_we && mem_ready;

  // A word arriving after the full count is an error, not a FIFO push.
  assign push_req   = sig_vld && collecting && !complete;
  assign push_acc   = push_req && (!fifo_full || pop);
  assign fifo_drop  = push_req && !push_acc;
  assign extra_word = sig_vld && collecting && complete;

  assign last_push  = push_acc && (tree == TREE_W'(SPX_FORS_TREES - 1))
                      && (pos == POS_W'(SPX_FORS_HEIGHT));
  // Includes a word pushed in the same cycle as fors_done.
  assign count_ok   = complete || last_push;
  // Finish the drain on the cycle the last pending word is accepted.
  assign drain_fin  = !push_acc && (fifo_empty || (fifo_last && pop));

  fors_sig_writer_sig_fifo #(
    .WIDTH (256),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_acc),
    .wdata (sig_word),
    .pop   (pop),
    .rdata (mem_wdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .last  (fifo_last)
  );

  // Leaf/auth-node position within the current tree; complete marks all words received.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tree     <= '0;
      pos      <= '0;
      complete <= 1'b0;
    end else if (start_acc) begin
      tree     <= '0;
      pos      <= '0;
      complete <= 1'b0;
    end else if (push_acc) begin
      if (pos == POS_W'(SPX_FORS_HEIGHT)) begin
        pos <= '0;
        if (tree == TREE_W'(SPX_FORS_TREES - 1)) complete <= 1'b1;
        else                                     tree     <= tree + 1'b1;
      end else begin
        pos <= pos + 1'b1;
      end
    end
  end

  // SRAM write address: loaded from sig_base on start, advances on each accepted write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          mem_addr <= '0;
    else if (start_acc) mem_addr <= sig_base;
    else if (pop)       mem_addr <= mem_addr + 1'b1;
  end

  // Sequencing FSM with registered busy/done/fors_pk/overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      fors_pk  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (fifo_drop || extra_word) overflow <= 1'b1;
          if (fors_done) begin
            fors_pk <= fors_root;
            if (!count_ok) overflow <= 1'b1;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_drop || extra_word) overflow <= 1'b1;
          if (drain_fin) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fors_sig_writer.sv
// Randomized bench for fors_sig_writer. The reference model tracks the
// ordered list of accepted words (a queue of address/data pairs) and the
// sticky error flag from the stream rules, and is stepped once per cycle.
module tb_fors_sig_writer;

  localparam int WORDS = 22 * (1 + 14);
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [11:0]  sig_base;
  logic         sig_vld;
  logic [255:0] sig_word;
  logic         fors_done;
  logic [255:0] fors_root;
  logic         mem_we;
  logic [11:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_ready;
  logic         busy;
  logic         done;
  logic [255:0] fors_pk;
  logic         overflow;

  fors_sig_writer #(.ADDR_W(12), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .sig_base  (sig_base),
    .sig_vld   (sig_vld),
    .sig_word  (sig_word),
    .fors_done (fors_done),
    .fors_root (fors_root),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .fors_pk   (fors_pk),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [11:0]  qa[$];
  logic [255:0] qd[$];
  logic [11:0]  m_base;
  int           m_acc;
  logic         m_active, m_idle, m_wait, m_ovf;
  logic [255:0] m_pk;
  int           cycn, last_pop, fd_cyc, rmode, stall_end;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cycn);
    end
  endtask

  function automatic logic [255:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic ready_now();
    case (rmode)
      1:       return (cycn % 4) == 3;
      2:       return 1'($urandom_range(0, 1));
      3:       return cycn >= stall_end;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One clock cycle: drive inputs, step the model, check outputs at the negedge.
  task automatic cyc_step(input logic strt, input logic [11:0] base, input logic vld,
                          input logic [255:0] word, input logic fd, input logic [255:0] root);
    logic         rdy, exp_we, popm, ovf_before, idle_before, exp_done;
    logic [255:0] pk_before;
    rdy         = ready_now();
    start       = strt;
    sig_base    = base;
    sig_vld     = vld;
    sig_word    = word;
    fors_done   = fd;
    fors_root   = root;
    mem_ready   = rdy;
    ovf_before  = m_ovf;
    pk_before   = m_pk;
    idle_before = m_idle;
    exp_we      = (qa.size() > 0);
    popm        = exp_we && rdy;
    if (vld && m_active) begin
      if (m_acc < WORDS && (qa.size() < DEPTH || popm)) begin
        qa.push_back(12'(int'(m_base) + m_acc));
        qd.push_back(word);
        m_acc++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (fd && m_active) begin
      m_active = 1'b0;
      m_pk     = root;
      if (m_acc != WORDS) m_ovf = 1'b1;
      fd_cyc   = cycn;
      m_wait   = 1'b1;
    end
    if (strt && m_idle) begin
      m_idle   = 1'b0;
      m_active = 1'b1;
      m_acc    = 0;
      m_base   = base;
      m_ovf    = 1'b0;
      last_pop = -10;
    end
    @(negedge clk);
    chk("mem_we", mem_we, exp_we);
    if (popm) begin
      chk("mem_addr", mem_addr, qa.pop_front());
      chk("mem_wdata", mem_wdata, qd.pop_front());
      last_pop = cycn;
    end
    chk("overflow", overflow, ovf_before);
    chk("fors_pk", fors_pk, pk_before);
    chk("busy", busy, !idle_before);
    exp_done = m_wait && !m_active && (qa.size() == 0)
               && (cycn == imax(last_pop + 1, fd_cyc + 2));
    chk("done", done, exp_done);
    if (exp_done) begin
      m_wait = 1'b0;
      m_idle = 1'b1;
    end
    @(posedge clk);
    #1;
    cycn++;
  endtask

  task automatic idle_step();
    cyc_step(1'b0, 12'h0, 1'b0, '0, 1'b0, '0);
  endtask

  // One signature: start, nwords words spaced by gap, then fors_done.
  // fd_delay < 0 puts fors_done on the last word's cycle.
  task automatic run(input logic [11:0] base, input int nwords, input int gap,
                     input int mode, input int fd_delay, input int stray_start_at);
    logic [255:0] root;
    root  = rand_word();
    rmode = mode;
    if (mode == 3) stall_end = cycn + 10;
    cyc_step(1'b1, base, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < nwords; i++) begin
      logic fdn;
      fdn = (fd_delay < 0) && (i == nwords - 1);
      cyc_step(i == stray_start_at, 12'h555, 1'b1, rand_word(), fdn, fdn ? root : '0);
      for (int g = 1; g < gap; g++) idle_step();
    end
    if (fd_delay >= 0) begin
      for (int k = 0; k < fd_delay; k++) idle_step();
      cyc_step(1'b0, 12'h0, 1'b0, '0, 1'b1, root);
    end
    for (int k = 0; k < 3000 && m_wait; k++) idle_step();
    chk("done_timeout", m_wait, 1'b0);
    idle_step();
  endtask

  task automatic model_reset();
    qa.delete();
    qd.delete();
    m_active = 1'b0;
    m_idle   = 1'b1;
    m_wait   = 1'b0;
    m_ovf    = 1'b0;
    m_pk     = '0;
    m_acc    = 0;
    m_base   = '0;
  endtask

  initial begin
    cycn      = 0;
    last_pop  = -10;
    fd_cyc    = -10;
    rmode     = 0;
    stall_end = 0;
    model_reset();
    rstn      = 1'b0;
    start     = 1'b0;
    sig_base  = '0;
    sig_vld   = 1'b0;
    sig_word  = '0;
    fors_done = 1'b0;
    fors_root = '0;
    mem_ready = 1'b0;
    #3;
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_fors_pk", fors_pk, '0);
    chk("rst_mem_addr", mem_addr, '0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    run(12'h100, WORDS, 1, 0, 10, 50);          // nominal, with an ignored stray start
    run(12'h200, WORDS, 4, 1, 3, -1);           // stalled SRAM, sparse words
    run(12'h040, WORDS, 1, 3, 2, -1);           // SRAM stalled long enough to overflow FIFO
    run(12'hFFE, WORDS, 1, 0, 10, -1);          // address wrap
    run(12'h300, WORDS - 1, 1, 0, 4, -1);       // one word short
    run(12'h100, WORDS, 1, 0, 10, -1);          // overflow cleared by new start
    run(12'h310, WORDS + 1, 1, 0, 4, -1);       // one word too many
    run(12'h7F0, WORDS, 1, 1, -1, -1);          // fors_done with the last word, stalled drain
    run(12'($urandom), WORDS, 2, 2, -1, -1);    // random SRAM ready
    run(12'($urandom), WORDS, 1, 2, 5, -1);     // random ready, back-to-back words

    // reset in the middle of a signature
    rmode = 0;
    cyc_step(1'b1, 12'h0A0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 100; i++) cyc_step(1'b0, 12'h0, 1'b1, rand_word(), 1'b0, '0);
    rstn = 1'b0;
    #1;
    chk("midrst_mem_we", mem_we, 1'b0);
    chk("midrst_mem_addr", mem_addr, '0);
    chk("midrst_mem_wdata", mem_wdata, '0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_fors_pk", fors_pk, '0);
    chk("midrst_overflow", overflow, 1'b0);
    model_reset();
    sig_vld = 1'b0;
    @(posedge clk);
    #1;
    cycn++;
    rstn = 1'b1;
    run(12'h100, WORDS, 1, 0, 10, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
